// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ALU operation encoding and ID/EX operand-stage bus
package risc_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

interface ex_operand_stage_if #(parameter int RAW = 5);
    import risc_pkg::*;

    logic           id_valid;
    logic           id_ready;
    logic [31:0]    id_pc;
    logic [RAW-1:0] id_rs1_addr;
    logic [RAW-1:0] id_rs2_addr;
    logic [31:0]    id_rs1_data;
    logic [31:0]    id_rs2_data;
    logic [31:0]    id_imm;
    logic           id_a_sel_pc;
    logic           id_b_sel_imm;
    alu_op_t        id_alu_op;
    logic [RAW-1:0] id_rd_addr;
    logic           id_rd_we;
    logic           flush;
    logic           mem_fwd_we;
    logic [RAW-1:0] mem_fwd_rd;
    logic [31:0]    mem_fwd_data;
    logic           mem_fwd_is_load;
    logic           wb_fwd_we;
    logic [RAW-1:0] wb_fwd_rd;
    logic [31:0]    wb_fwd_data;
    logic           ex_ready;
    logic           ex_valid;
    logic [31:0]    alu_a;
    logic [31:0]    alu_b;
    alu_op_t        alu_op;
    logic [31:0]    ex_pc;
    logic [RAW-1:0] ex_rd_addr;
    logic           ex_rd_we;
    logic [31:0]    ex_store_data;
    logic [31:0]    stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_a_sel_pc, id_b_sel_imm, id_alu_op, id_rd_addr, id_rd_we,
               flush, mem_fwd_we, mem_fwd_rd, mem_fwd_data, mem_fwd_is_load,
               wb_fwd_we, wb_fwd_rd, wb_fwd_data, ex_ready,
        input  id_ready, ex_valid, alu_a, alu_b, alu_op, ex_pc, ex_rd_addr, ex_rd_we,
               ex_store_data, stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_a_sel_pc, id_b_sel_imm, id_alu_op, id_rd_addr, id_rd_we,
               flush, mem_fwd_we, mem_fwd_rd, mem_fwd_data, mem_fwd_is_load,
               wb_fwd_we, wb_fwd_rd, wb_fwd_data, ex_ready,
        output id_ready, ex_valid, alu_a, alu_b, alu_op, ex_pc, ex_rd_addr, ex_rd_we,
               ex_store_data, stall_cnt
    );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with MEM/WB forwarding and load-use bubble
module ex_operand_stage
    import risc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    ex_operand_stage_if.slave bus
);

    if (XLEN != 32) begin : g_xlen_check
        $error("ex_operand_stage: XLEN must be 32");
    end

    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [RAW-1:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic            a_sel_pc_q, b_sel_imm_q, rd_we_q;
    alu_op_t         op_q;
    logic            valid_q, valid_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            load_in_mem, load_hazard, ex_valid, fire, id_ready, accept;

    // MEM wins over WB; a load in MEM has no data yet so it never forwards.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RAW-1:0]  addr,
        input logic [XLEN-1:0] held,
        input logic            mem_we,
        input logic [RAW-1:0]  mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            mem_is_load,
        input logic            wb_we,
        input logic [RAW-1:0]  wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (addr == '0)                                 return '0;
        else if (mem_we && mem_rd == addr && !mem_is_load) return mem_data;
        else if (wb_we && wb_rd == addr)                return wb_data;
        else                                            return held;
    endfunction

    assign fwd_rs1 = resolve(rs1_addr_q, rs1_data_q, bus.mem_fwd_we, bus.mem_fwd_rd,
                             bus.mem_fwd_data, bus.mem_fwd_is_load, bus.wb_fwd_we,
                             bus.wb_fwd_rd, bus.wb_fwd_data);
    assign fwd_rs2 = resolve(rs2_addr_q, rs2_data_q, bus.mem_fwd_we, bus.mem_fwd_rd,
                             bus.mem_fwd_data, bus.mem_fwd_is_load, bus.wb_fwd_we,
                             bus.wb_fwd_rd, bus.wb_fwd_data);

    // rs2 always counts as used because stores consume it as store data.
    assign load_in_mem = bus.mem_fwd_is_load && bus.mem_fwd_we && (bus.mem_fwd_rd != '0);
    assign load_hazard = valid_q && load_in_mem &&
                         (((bus.mem_fwd_rd == rs1_addr_q) && !a_sel_pc_q) ||
                          (bus.mem_fwd_rd == rs2_addr_q));

    assign ex_valid = valid_q && !load_hazard && !bus.flush;
    assign fire     = ex_valid && bus.ex_ready;
    assign id_ready = !valid_q || fire || bus.flush;
    assign accept   = bus.id_valid && id_ready && !bus.flush;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush)   valid_d = 1'b0;
        else if (accept) valid_d = 1'b1;
        else if (fire)   valid_d = 1'b0;

        stall_cnt_d = stall_cnt_q;
        if (load_hazard && !bus.flush && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            a_sel_pc_q  <= 1'b0;
            b_sel_imm_q <= 1'b0;
            op_q        <= ALU_ADD;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            if (accept) begin
                pc_q        <= bus.id_pc;
                rs1_addr_q  <= bus.id_rs1_addr;
                rs2_addr_q  <= bus.id_rs2_addr;
                rs1_data_q  <= bus.id_rs1_data;
                rs2_data_q  <= bus.id_rs2_data;
                imm_q       <= bus.id_imm;
                a_sel_pc_q  <= bus.id_a_sel_pc;
                b_sel_imm_q <= bus.id_b_sel_imm;
                op_q        <= bus.id_alu_op;
                rd_addr_q   <= bus.id_rd_addr;
                rd_we_q     <= bus.id_rd_we;
            end
        end
    end

    assign bus.id_ready      = id_ready;
    assign bus.ex_valid      = ex_valid;
    assign bus.alu_a         = a_sel_pc_q ? pc_q : fwd_rs1;
    assign bus.alu_b         = b_sel_imm_q ? imm_q : fwd_rs2;
    assign bus.alu_op        = op_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_rd_addr    = rd_addr_q;
    assign bus.ex_rd_we      = rd_we_q;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule
